// File: rtl/syml_freq_count.sv
// rtl/syml_freq_count.sv - symbol frequency counter: builds a distinct-symbol table, then streams (symbol, count) pairs
// Symbols are stored in allocation order, so valid entries are always the contiguous prefix [0, cnt_q).
module syml_freq_count #(
    parameter int MAX_SYML = 20,
    parameter int FREQ_W   = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        Data_in,
    input  logic              Data_valid,
    input  logic              Data_last,
    output logic              Data_ready,
    output logic [7:0]        Syml,
    output logic [FREQ_W-1:0] Freq,
    output logic              Syml_pulse,
    output logic              fdone,
    output logic              Ovf
);

    localparam int CW = $clog2(MAX_SYML + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_COUNT,
        S_EMIT,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [7:0]          syml_tab_q [MAX_SYML];
    logic [7:0]          syml_tab_d [MAX_SYML];
    logic [FREQ_W-1:0]   freq_tab_q [MAX_SYML];
    logic [FREQ_W-1:0]   freq_tab_d [MAX_SYML];
    logic [MAX_SYML-1:0] valid_q, valid_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [CW-1:0]       idx_q, idx_d;

    logic                ready_q, ready_d;
    logic [7:0]          syml_q, syml_d;
    logic [FREQ_W-1:0]   freq_q, freq_d;
    logic                pulse_q, pulse_d;
    logic                done_q, done_d;
    logic                ovf_q, ovf_d;

    logic                hit;
    logic [CW-1:0]       hit_idx;
    logic                accept;

    assign accept = Data_valid && ready_q;

    // Parallel match against every valid entry; at most one can hit.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = 0; i < MAX_SYML; i++) begin
            if (valid_q[i] && (syml_tab_q[i] == Data_in) && !hit) begin
                hit     = 1'b1;
                hit_idx = CW'(i);
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        syml_tab_d = syml_tab_q;
        freq_tab_d = freq_tab_q;
        valid_d    = valid_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        ready_d    = ready_q;
        syml_d     = '0;
        freq_d     = '0;
        pulse_d    = 1'b0;
        done_d     = done_q;
        ovf_d      = ovf_q;

        case (state_q)
            S_IDLE, S_COUNT: begin
                if (accept) begin
                    if (hit) begin
                        if (freq_tab_q[hit_idx] != {FREQ_W{1'b1}}) begin
                            freq_tab_d[hit_idx] = freq_tab_q[hit_idx] + 1'b1;
                        end
                    end else if (cnt_q < CW'(MAX_SYML)) begin
                        syml_tab_d[cnt_q] = Data_in;
                        freq_tab_d[cnt_q] = FREQ_W'(1);
                        valid_d[cnt_q]    = 1'b1;
                        cnt_d             = cnt_q + 1'b1;
                    end else begin
                        ovf_d = 1'b1;
                    end
                    if (Data_last) begin
                        state_d = S_EMIT;
                        ready_d = 1'b0;
                        idx_d   = '0;
                    end else begin
                        state_d = S_COUNT;
                    end
                end
            end
            S_EMIT: begin
                if (idx_q < cnt_q) begin
                    syml_d  = syml_tab_q[idx_q];
                    freq_d  = freq_tab_q[idx_q];
                    pulse_d = 1'b1;
                    idx_d   = idx_q + 1'b1;
                end else begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = S_DONE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            for (int i = 0; i < MAX_SYML; i++) begin
                syml_tab_q[i] <= '0;
                freq_tab_q[i] <= '0;
            end
            valid_q <= '0;
            cnt_q   <= '0;
            idx_q   <= '0;
            ready_q <= 1'b1;
            syml_q  <= '0;
            freq_q  <= '0;
            pulse_q <= 1'b0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            syml_tab_q <= syml_tab_d;
            freq_tab_q <= freq_tab_d;
            valid_q    <= valid_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            ready_q    <= ready_d;
            syml_q     <= syml_d;
            freq_q     <= freq_d;
            pulse_q    <= pulse_d;
            done_q     <= done_d;
            ovf_q      <= ovf_d;
        end
    end

    assign Data_ready = ready_q;
    assign Syml       = syml_q;
    assign Freq       = freq_q;
    assign Syml_pulse = pulse_q;
    assign fdone      = done_q;
    assign Ovf        = ovf_q;

endmodule
